// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the view of the stages plus memory.
interface mem_port_arbiter_if;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_ready;
    logic [31:0] i_data;
    logic        d_valid;
    logic [63:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_ready;
    logic [63:0] d_rdata;
    logic        m_valid;
    logic [63:0] m_addr;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_ready;
    logic [63:0] m_rdata;
    logic        owner;
    logic        busy;

    modport slave (
        input  i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata, m_ready, m_rdata,
        output i_ready, i_data, d_ready, d_rdata, m_valid, m_addr, m_size, m_strobe, m_wdata,
               owner, busy
    );

    modport master (
        output i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata, m_ready, m_rdata,
        input  i_ready, i_data, d_ready, d_rdata, m_valid, m_addr, m_size, m_strobe, m_wdata,
               owner, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and LD/SD, one transaction at a time.
// ARB_ROUND_ROBIN_EN: strict alternation on contention instead of data-priority with streak limit.
module mem_port_arbiter #(
    parameter int MAX_STREAK = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t      r_state, w_next;
    logic        w_grant, w_pick_data;
    logic [63:0] r_m_addr;
    logic [2:0]  r_m_size;
    logic [7:0]  r_m_strobe;
    logic [63:0] r_m_wdata;
    logic        r_owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.i_valid || bus.d_valid) begin
                w_grant = 1'b1;
                w_next  = ST_BUSY;
            end
            ST_BUSY: if (bus.m_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef ARB_ROUND_ROBIN_EN
    // last_owner resets to data so the first contended grant goes to fetch
    logic r_last_owner;

    always_comb begin
        if (bus.i_valid && bus.d_valid) w_pick_data = ~r_last_owner;
        else                            w_pick_data = bus.d_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        r_last_owner <= 1'b1;
        else if (w_grant) r_last_owner <= w_pick_data;
    end
`else
    localparam logic [3:0] LP_MAX = 4'(MAX_STREAK);
    logic [3:0] r_streak;

    always_comb begin
        if (bus.i_valid && bus.d_valid) w_pick_data = (r_streak != LP_MAX);
        else                            w_pick_data = bus.d_valid;
    end

    // Only data grants that actually starve a waiting fetch extend the streak
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_streak <= 4'd0;
        end else if (w_grant) begin
            if (w_pick_data && bus.i_valid)
                r_streak <= (r_streak == LP_MAX) ? LP_MAX : r_streak + 4'd1;
            else
                r_streak <= 4'd0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_addr   <= 64'd0;
            r_m_size   <= 3'd0;
            r_m_strobe <= 8'd0;
            r_m_wdata  <= 64'd0;
            r_owner    <= 1'b0;
        end else if (w_grant) begin
            r_owner <= w_pick_data;
            if (w_pick_data) begin
                r_m_addr   <= bus.d_addr;
                r_m_size   <= bus.d_size;
                r_m_strobe <= bus.d_strobe;
                r_m_wdata  <= bus.d_wdata;
            end else begin
                r_m_addr   <= bus.i_addr;
                r_m_size   <= 3'd2;
                r_m_strobe <= 8'd0;
                r_m_wdata  <= 64'd0;
            end
        end
    end

    logic w_busy;
    assign w_busy       = (r_state == ST_BUSY);
    assign bus.m_valid  = w_busy;
    assign bus.busy     = w_busy;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_size   = r_m_size;
    assign bus.m_strobe = r_m_strobe;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.owner    = r_owner;
    assign bus.i_ready  = w_busy && bus.m_ready && !r_owner;
    assign bus.d_ready  = w_busy && bus.m_ready && r_owner;
    assign bus.i_data   = r_m_addr[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
    assign bus.d_rdata  = bus.m_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch/store paths, arbitration order, reset abort.
// Inputs change on the falling edge; outputs are sampled shortly after.
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    mem_port_arbiter_if u_if();

    mem_port_arbiter #(.MAX_STREAK(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        u_if.i_valid  = 1'b0; u_if.i_addr  = '0;
        u_if.d_valid  = 1'b0; u_if.d_addr  = '0; u_if.d_size = '0;
        u_if.d_strobe = '0;   u_if.d_wdata = '0;
        u_if.m_ready  = 1'b0; u_if.m_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_valid", u_if.m_valid, 0);
        chk("rst_busy",    u_if.busy,    0);
        chk("rst_owner",   u_if.owner,   0);
        chk("rst_m_addr",  u_if.m_addr,  0);
        chk("rst_readies", {u_if.i_ready, u_if.d_ready}, 0);
        reset = 1'b0;

        // fetch, upper word
        @(negedge clk);
        u_if.i_valid = 1'b1; u_if.i_addr = 64'h8000_0004;
        @(negedge clk); #1;
        chk("f1_m_valid", u_if.m_valid, 1);
        chk("f1_m_addr",  u_if.m_addr,  64'h8000_0004);
        chk("f1_m_size",  u_if.m_size,  2);
        chk("f1_m_strobe",u_if.m_strobe,0);
        chk("f1_owner",   u_if.owner,   0);
        chk("f1_i_ready_pre", u_if.i_ready, 0);
        u_if.m_ready = 1'b1; u_if.m_rdata = 64'h1111_2222_3333_4444;
        #1;
        chk("f1_i_ready", u_if.i_ready, 1);
        chk("f1_d_ready", u_if.d_ready, 0);
        chk("f1_i_data",  u_if.i_data,  32'h1111_2222);
        @(negedge clk);
        u_if.m_ready = 1'b0; u_if.i_valid = 1'b0;
        #1;
        chk("f1_idle_busy", u_if.busy, 0);

        // fetch, lower word
        u_if.i_valid = 1'b1; u_if.i_addr = 64'h8000_0000;
        @(negedge clk);
        u_if.m_ready = 1'b1;
        #1;
        chk("f2_i_data", u_if.i_data, 32'h3333_4444);
        @(negedge clk);
        u_if.m_ready = 1'b0; u_if.i_valid = 1'b0;

        // store
        u_if.d_valid = 1'b1; u_if.d_addr = 64'h100; u_if.d_size = 3'd3;
        u_if.d_strobe = 8'hFF; u_if.d_wdata = 64'hDEAD;
        @(negedge clk); #1;
        chk("sd_m_addr",   u_if.m_addr,   64'h100);
        chk("sd_m_size",   u_if.m_size,   3);
        chk("sd_m_strobe", u_if.m_strobe, 8'hFF);
        chk("sd_m_wdata",  u_if.m_wdata,  64'hDEAD);
        chk("sd_owner",    u_if.owner,    1);
        u_if.m_ready = 1'b1; u_if.m_rdata = 64'hCAFE_0000_BEEF_0001;
        #1;
        chk("sd_d_ready", u_if.d_ready, 1);
        chk("sd_i_ready", u_if.i_ready, 0);
        chk("sd_d_rdata", u_if.d_rdata, 64'hCAFE_0000_BEEF_0001);
        @(negedge clk);
        u_if.m_ready = 1'b0; u_if.d_valid = 1'b0;

        // contention: both valid for ten grants
        u_if.i_valid = 1'b1; u_if.i_addr = 64'h200;
        u_if.d_valid = 1'b1; u_if.d_addr = 64'h300; u_if.d_strobe = 8'h00;
        for (int k = 0; k < 10; k++) begin
            logic exp_d;
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (k % 2) == 1;
`else
            exp_d = (k % 5) != 4;
`endif
            @(negedge clk);
            #1;
            chk($sformatf("arb_owner%0d", k), u_if.owner, exp_d);
            chk($sformatf("arb_addr%0d", k), u_if.m_addr, exp_d ? 64'h300 : 64'h200);
            u_if.m_ready = 1'b1;
            #1;
            chk($sformatf("arb_rdy%0d", k), {u_if.d_ready, u_if.i_ready}, exp_d ? 2'b10 : 2'b01);
            @(negedge clk);
            u_if.m_ready = 1'b0;
        end
        u_if.i_valid = 1'b0; u_if.d_valid = 1'b0;

        // reset while busy
        @(negedge clk);
        u_if.d_valid = 1'b1; u_if.d_addr = 64'h440;
        @(negedge clk); #1;
        chk("rb_m_valid_pre", u_if.m_valid, 1);
        u_if.m_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("rb_m_valid", u_if.m_valid, 0);
        chk("rb_busy",    u_if.busy,    0);
        chk("rb_readies", {u_if.i_ready, u_if.d_ready}, 0);
        @(negedge clk);
        reset = 1'b0; u_if.m_ready = 1'b0;
        @(negedge clk); #1;
        chk("rb_regrant_valid", u_if.m_valid, 1);
        chk("rb_regrant_addr",  u_if.m_addr,  64'h440);
        chk("rb_regrant_owner", u_if.owner,   1);
        u_if.m_ready = 1'b1;
        #1;
        chk("rb_regrant_d_ready", u_if.d_ready, 1);
        @(negedge clk);
        u_if.m_ready = 1'b0; u_if.d_valid = 1'b0;

        // stray m_ready while idle
        @(negedge clk);
        u_if.m_ready = 1'b1;
        #1;
        chk("idle_readies", {u_if.i_ready, u_if.d_ready}, 0);
        @(negedge clk);
        u_if.m_ready = 1'b0;
        #1;
        chk("idle_m_valid", u_if.m_valid, 0);
        chk("idle_busy",    u_if.busy,    0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
